// File: rtl/logic_trainer_pkg.sv
// rtl/logic_trainer_pkg.sv - operation and state encodings shared by the logic trainer
package logic_trainer_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NOTA = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;
    localparam logic [2:0] OP_BUF  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_SWEEP  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/logic_trainer_alu.sv
// rtl/logic_trainer_alu.sv - combinational WIDTH-bit eight-operation logic unit
module logic_trainer_alu
    import logic_trainer_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op_sel,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op_sel)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NOTA: y = ~a;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            OP_BUF:  y = a;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/logic_trainer_seq.sv
// rtl/logic_trainer_seq.sv - manual/sweep logic trainer core; TRAINER_SIG_EN adds a sweep signature
module logic_trainer_seq
    import logic_trainer_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic               start,
    input  logic               pause,
    input  logic [2:0]         op_sel,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic [WIDTH-1:0]   a_cur,
    output logic [WIDTH-1:0]   b_cur,
    output logic [WIDTH-1:0]   y_out,
    output logic               valid,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   sig_out
);

    localparam int CW = 2 * WIDTH;

    state_t             state;
    logic [DWELL_W-1:0] dcnt;
    logic [DWELL_W-1:0] dwell_q;
    logic [WIDTH-1:0]   y_cur;
    logic [WIDTH-1:0]   y_man;
    logic               launch;
    logic               combo_end;

    logic_trainer_alu #(.WIDTH(WIDTH)) u_alu_cur (
        .a      (a_cur),
        .b      (b_cur),
        .op_sel (op_sel),
        .y      (y_cur)
    );

    logic_trainer_alu #(.WIDTH(WIDTH)) u_alu_man (
        .a      (a_in),
        .b      (b_in),
        .op_sel (op_sel),
        .y      (y_man)
    );

    assign launch    = (state == ST_IDLE || state == ST_DONE) && mode && start;
    assign combo_end = (state == ST_SWEEP) && mode && !pause && (dcnt == dwell_q);

    // In SWEEP the {a_cur, b_cur} pair is itself the combo counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            a_cur   <= '0;
            b_cur   <= '0;
            y_out   <= '0;
            dcnt    <= '0;
            dwell_q <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (!mode) begin
                        state <= ST_MANUAL;
                        valid <= 1'b0;
                        done  <= 1'b0;
                    end else if (start) begin
                        state   <= ST_SWEEP;
                        a_cur   <= '0;
                        b_cur   <= '0;
                        dcnt    <= '0;
                        dwell_q <= dwell;
                        valid   <= 1'b0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end else if (state == ST_DONE) begin
                        y_out <= y_cur;
                        valid <= 1'b1;
                    end
                end
                ST_MANUAL: begin
                    if (mode) begin
                        state <= ST_IDLE;
                        valid <= 1'b0;
                    end else begin
                        a_cur <= a_in;
                        b_cur <= b_in;
                        y_out <= y_man;
                        valid <= 1'b1;
                    end
                end
                ST_SWEEP: begin
                    y_out <= y_cur;
                    if (!mode) begin
                        state <= ST_MANUAL;
                        a_cur <= '0;
                        b_cur <= '0;
                        dcnt  <= '0;
                        busy  <= 1'b0;
                        valid <= 1'b0;
                    end else if (pause) begin
                        valid <= 1'b1;
                    end else if (dcnt != dwell_q) begin
                        dcnt  <= dcnt + DWELL_W'(1);
                        valid <= 1'b1;
                    end else if (&{a_cur, b_cur}) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        valid <= 1'b1;
                    end else begin
                        {a_cur, b_cur} <= {a_cur, b_cur} + CW'(1);
                        dcnt    <= '0;
                        dwell_q <= dwell;
                        valid   <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef TRAINER_SIG_EN
    logic [WIDTH-1:0] sig;

    // Folds in the result of the applied combo, not the lagging y_out register.
    always_ff @(posedge clk) begin
        if (rst || launch) begin
            sig <= '0;
        end else if (combo_end) begin
            sig <= ((sig << 1) | (sig >> (WIDTH - 1))) ^ y_cur;
        end
    end

    assign sig_out = sig;
`else
    assign sig_out = '0;
`endif

endmodule

// File: tb/tb_logic_trainer_seq.sv
// tb/tb_logic_trainer_seq.sv - directed self-checking bench for logic_trainer_seq
module tb_logic_trainer_seq;

`ifdef TRAINER_SIG_EN
    localparam logic SIG_AND = 1'b1;
`else
    localparam logic SIG_AND = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pause = 1'b0;
    logic [2:0] op_sel = 3'd0;
    logic [7:0] dwell = 8'd0;

    logic       mode1 = 1'b1, start1 = 1'b0, a_in1 = 1'b0, b_in1 = 1'b0;
    logic       a1, b1, y1, valid1, busy1, done1, sig1;

    logic       mode2 = 1'b1, start2 = 1'b0;
    logic [1:0] a_in2 = 2'd0, b_in2 = 2'd0;
    logic [1:0] a2, b2, y2, sig2;
    logic       valid2, busy2, done2;

    int vectors = 0;
    int miscompares = 0;

    // Truth-table columns, bit index = {a,b}
    logic [3:0] tbl [7] = '{4'b1000, 4'b1110, 4'b0011, 4'b0111, 4'b0001, 4'b0110, 4'b1001};

    int         hold [16];
    int         busy_cycles;
    int         pause_left;
    logic       paused_once;
    logic       op_chk;
    logic [1:0] ab;

    always #5 clk = ~clk;

    logic_trainer_seq #(.WIDTH(1), .DWELL_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .mode(mode1), .start(start1), .pause(pause),
        .op_sel(op_sel), .dwell(dwell), .a_in(a_in1), .b_in(b_in1),
        .a_cur(a1), .b_cur(b1), .y_out(y1), .valid(valid1), .busy(busy1),
        .done(done1), .sig_out(sig1)
    );

    logic_trainer_seq #(.WIDTH(2), .DWELL_W(8)) u_dut2 (
        .clk(clk), .rst(rst), .mode(mode2), .start(start2), .pause(pause),
        .op_sel(op_sel), .dwell(dwell), .a_in(a_in2), .b_in(b_in2),
        .a_cur(a2), .b_cur(b2), .y_out(y2), .valid(valid2), .busy(busy2),
        .done(done2), .sig_out(sig2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_done1(input string tag);
        for (int i = 0; i < 200; i++) begin
            if (done1) break;
            step();
        end
        check_eq(tag, done1, 1);
    endtask

    task automatic wait_combo2(input logic [3:0] v, input string tag);
        for (int i = 0; i < 200; i++) begin
            if ({a2, b2} == v) break;
            step();
        end
        check_eq(tag, {a2, b2}, v);
    endtask

    initial begin
        step();
        step();
        check_eq("reset_w1", {a1, b1, y1, valid1, busy1, done1, sig1}, 0);
        check_eq("reset_w2", {a2, b2, y2, valid2, busy2, done2, sig2}, 0);

        // Manual mode, WIDTH=1, every op over every input pair
        rst   = 1'b0;
        mode1 = 1'b0;
        step();
        for (int op = 0; op < 7; op++) begin
            for (int k = 0; k < 4; k++) begin
                op_sel = 3'(op);
                ab     = 2'(k);
                a_in1  = ab[1];
                b_in1  = ab[0];
                step();
                check_eq($sformatf("manual_op%0d_ab%0d", op, k), {valid1, a1, b1, y1},
                         {1'b1, ab, tbl[op][k]});
            end
        end

        // XOR sweep, no dwell
        mode1 = 1'b1;
        step();
        op_sel = 3'd5;
        dwell  = 8'd0;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        check_eq("xor_combo0", {busy1, valid1, a1, b1}, 4'b1000);
        for (int k = 1; k < 4; k++) begin
            step();
            ab = 2'(k);
            check_eq($sformatf("xor_combo%0d", k), {busy1, done1, a1, b1, y1},
                     {2'b10, ab, tbl[5][k-1]});
        end
        step();
        check_eq("xor_done", {busy1, done1, valid1, a1, b1, y1}, 6'b011110);

        // AND sweep signature, then a restart must clear and reproduce it
        op_sel = 3'd0;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        wait_done1("and_done1");
        check_eq("and_sig1", sig1, SIG_AND);
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        check_eq("and_sig_clear", {busy1, sig1}, 2'b10);
        wait_done1("and_done2");
        check_eq("and_sig2", {a1, b1, sig1}, {2'b11, SIG_AND});

        // WIDTH=2 sweep, dwell 2, pause for 5 cycles in combo 3
        op_sel = 3'd5;
        dwell  = 8'd2;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        for (int i = 0; i < 16; i++) hold[i] = 0;
        busy_cycles = 0;
        pause_left  = 0;
        paused_once = 1'b0;
        op_chk      = 1'b0;
        for (int i = 0; i < 120 && !done2; i++) begin
            if (op_chk) begin
                check_eq("pause_op_change", {valid2, y2}, 3'b100);
                op_chk = 1'b0;
            end
            if (busy2) begin
                busy_cycles++;
                hold[{a2, b2}]++;
            end
            if ({a2, b2} == 4'd3 && !paused_once) begin
                paused_once = 1'b1;
                pause_left  = 5;
            end
            pause = (pause_left > 0);
            if (pause_left == 3) begin
                op_sel = 3'd0;
                op_chk = 1'b1;
            end
            if (pause_left > 0) pause_left--;
            step();
        end
        check_eq("dwell_done", {done2, busy2, a2, b2}, 6'b101111);
        check_eq("dwell_total", busy_cycles, 53);
        check_eq("dwell_hold0", hold[0], 3);
        check_eq("dwell_hold3", hold[3], 8);
        check_eq("dwell_hold7", hold[7], 3);
        check_eq("dwell_hold15", hold[15], 3);

        // Abort by dropping mode at combo 5
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        wait_combo2(4'd5, "abort_reach5");
        mode2 = 1'b0;
        step();
        check_eq("abort_state", {done2, busy2, valid2, a2, b2}, 0);
        op_sel = 3'd1;
        a_in2  = 2'b10;
        b_in2  = 2'b01;
        step();
        check_eq("abort_manual", {valid2, a2, b2, y2}, 7'b1100111);

        // Reset at combo 5
        mode2 = 1'b1;
        step();
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        wait_combo2(4'd5, "reset_reach5");
        rst = 1'b1;
        step();
        check_eq("midreset_w2", {a2, b2, y2, valid2, busy2, done2, sig2}, 0);
        check_eq("midreset_w1", {a1, b1, y1, valid1, busy1, done1, sig1}, 0);
        rst = 1'b0;
        step();
        check_eq("midreset_idle", {busy2, done2, valid2, a2, b2}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
